router_sync: RTL and testbench

ROUTER_SYNC -- requirements
Module: router_sync

---
 rtl/router_sync.sv | 153 +++++++++++++++
 tb/tb_router_sync.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_sync.sv
// ---------------------------------------------------------------------------
// router_sync
//
// Synchronous N_IN x N_OUT channel crossbar with double-buffered select
// registers. A routing change is staged through stage_sel and becomes live
// for every output at once on a commit (update_in). When an output's live
// select changes, that output is blanked (forced to zero with dv low) for
// BLANK_CYC cycles, so downstream logic never sees a partial switch-over.
//
// Parameters
//   W_CHAN     width of each data channel in bits
//   W_SEL      width of the source/destination select fields
//   N_IN       number of input channels  (N_IN  <= 2**W_SEL)
//   N_OUT      number of output channels (N_OUT <= 2**W_SEL)
//   BLANK_CYC  blanking cycles after a select change (0 = no blanking)
//
// Ports
//   clk_in            system clock, rising edge
//   rst_in            synchronous active-high reset
//   data_packed_in    input channels, channel i at [i*W_CHAN +: W_CHAN]
//   dv_packed_in      per-input data-valid, bit i pairs with channel i
//   src_select_in     source index loaded by a staged write
//   dest_select_in    destination output for a non-broadcast write
//   bcast_in          with wr_in, write every staging register
//   wr_in             single-cycle staging write strobe
//   update_in         single-cycle commit strobe (stage_sel -> act_sel)
//   output_active_in  per-output enable
//   data_packed_out   registered outputs, channel k at [k*W_CHAN +: W_CHAN]
//   dv_packed_out     registered per-output data-valid
//   blank_out         bit k high while output k is blanking
// ---------------------------------------------------------------------------
module router_sync #(
    parameter int W_CHAN    = 16,
    parameter int W_SEL     = 4,
    parameter int N_IN      = 8,
    parameter int N_OUT     = 8,
    parameter int BLANK_CYC = 4
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [W_CHAN*N_IN-1:0]    data_packed_in,
    input  logic [N_IN-1:0]           dv_packed_in,
    input  logic [W_SEL-1:0]          src_select_in,
    input  logic [W_SEL-1:0]          dest_select_in,
    input  logic                      bcast_in,
    input  logic                      wr_in,
    input  logic                      update_in,
    input  logic [N_OUT-1:0]          output_active_in,
    output logic [W_CHAN*N_OUT-1:0]   data_packed_out,
    output logic [N_OUT-1:0]          dv_packed_out,
    output logic [N_OUT-1:0]          blank_out
);

    // Counter wide enough to hold BLANK_CYC; kept at least one bit so the
    // design still elaborates with blanking disabled.
    localparam int CW = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
    localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYC);

    typedef logic [W_SEL-1:0] sel_t;
    typedef logic [CW-1:0]    cnt_t;

    sel_t stage_sel_q [N_OUT];
    sel_t stage_sel_d [N_OUT];
    sel_t act_sel_q   [N_OUT];
    sel_t act_sel_d   [N_OUT];
    cnt_t blank_cnt_q [N_OUT];
    cnt_t blank_cnt_d [N_OUT];

    logic [W_CHAN*N_OUT-1:0] data_q;
    logic [W_CHAN*N_OUT-1:0] data_d;
    logic [N_OUT-1:0]        dv_q;
    logic [N_OUT-1:0]        dv_d;
    logic [N_OUT-1:0]        blank_q;
    logic [N_OUT-1:0]        blank_d;

    logic [W_CHAN-1:0]       chan_val;
    logic                    chan_dv;

    always_comb begin
        data_d   = '0;
        dv_d     = '0;
        blank_d  = '0;
        chan_val = '0;
        chan_dv  = 1'b0;

        for (int k = 0; k < N_OUT; k++) begin
            // Staging write. A destination >= N_OUT matches no k, so an
            // out-of-range write falls through and is ignored.
            stage_sel_d[k] = stage_sel_q[k];
            if (wr_in && (bcast_in || (dest_select_in == sel_t'(k)))) begin
                stage_sel_d[k] = src_select_in;
            end

            // The commit uses stage_sel_d so a write in the same cycle as
            // the commit is included in it.
            act_sel_d[k] = update_in ? stage_sel_d[k] : act_sel_q[k];

            blank_cnt_d[k] = blank_cnt_q[k];
            if ((BLANK_CYC > 0) && update_in && (stage_sel_d[k] != act_sel_q[k])) begin
                blank_cnt_d[k] = BLANK_LOAD;
            end else if (blank_cnt_q[k] != '0) begin
                blank_cnt_d[k] = blank_cnt_q[k] - cnt_t'(1);
            end

            blank_d[k] = (blank_cnt_d[k] != '0);

            // Routing looks at the post-commit select and counter so the
            // output register already reflects a commit in the cycle right
            // after the commit edge, aligned with blank_out. Selects that
            // match no input leave the channel at zero.
            chan_val = '0;
            chan_dv  = 1'b0;
            for (int i = 0; i < N_IN; i++) begin
                if (act_sel_d[k] == sel_t'(i)) begin
                    chan_val = data_packed_in[i*W_CHAN +: W_CHAN];
                    chan_dv  = dv_packed_in[i];
                end
            end

            if (output_active_in[k] && (blank_cnt_d[k] == '0)) begin
                data_d[k*W_CHAN +: W_CHAN] = chan_val;
                dv_d[k]                    = chan_dv;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int k = 0; k < N_OUT; k++) begin
                stage_sel_q[k] <= '0;
                act_sel_q[k]   <= '0;
                blank_cnt_q[k] <= '0;
            end
            data_q  <= '0;
            dv_q    <= '0;
            blank_q <= '0;
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                stage_sel_q[k] <= stage_sel_d[k];
                act_sel_q[k]   <= act_sel_d[k];
                blank_cnt_q[k] <= blank_cnt_d[k];
            end
            data_q  <= data_d;
            dv_q    <= dv_d;
            blank_q <= blank_d;
        end
    end

    assign data_packed_out = data_q;
    assign dv_packed_out   = dv_q;
    assign blank_out       = blank_q;

endmodule

// File: tb/tb_router_sync.sv
// ---------------------------------------------------------------------------
// tb_router_sync
//
// Directed bench for router_sync. A behavioural model tracks the staged and
// live routing tables plus the number of blanked cycles still owed per
// output, and a compare process checks every output each cycle. Literal
// expectations at key points pin the model to hand-derived values.
// ---------------------------------------------------------------------------
module tb_router_sync;

    localparam int W     = 16;
    localparam int WS    = 4;
    localparam int NI    = 8;
    localparam int NO    = 8;
    localparam int BLANK = 4;

    logic                clk_in;
    logic                rst_in;
    logic [W*NI-1:0]     data_packed_in;
    logic [NI-1:0]       dv_packed_in;
    logic [WS-1:0]       src_select_in;
    logic [WS-1:0]       dest_select_in;
    logic                bcast_in;
    logic                wr_in;
    logic                update_in;
    logic [NO-1:0]       output_active_in;
    logic [W*NO-1:0]     data_packed_out;
    logic [NO-1:0]       dv_packed_out;
    logic [NO-1:0]       blank_out;

    router_sync #(
        .W_CHAN(W), .W_SEL(WS), .N_IN(NI), .N_OUT(NO), .BLANK_CYC(BLANK)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .data_packed_in(data_packed_in),
        .dv_packed_in(dv_packed_in),
        .src_select_in(src_select_in),
        .dest_select_in(dest_select_in),
        .bcast_in(bcast_in),
        .wr_in(wr_in),
        .update_in(update_in),
        .output_active_in(output_active_in),
        .data_packed_out(data_packed_out),
        .dv_packed_out(dv_packed_out),
        .blank_out(blank_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: routing tables and owed blank cycles, updated at each edge.
    // ------------------------------------------------------------------
    int              m_stage [NO];
    int              m_act   [NO];
    int              m_left  [NO];
    logic [W*NO-1:0] m_data;
    logic [NO-1:0]   m_dv;
    logic [NO-1:0]   m_blank;
    bit              model_ok = 0;

    always @(posedge clk_in) begin
        if (rst_in) begin
            for (int k = 0; k < NO; k++) begin
                m_stage[k] = 0;
                m_act[k]   = 0;
                m_left[k]  = 0;
            end
            m_data  = '0;
            m_dv    = '0;
            m_blank = '0;
        end else begin
            if (wr_in) begin
                if (bcast_in) begin
                    for (int k = 0; k < NO; k++) m_stage[k] = int'(src_select_in);
                end else if (int'(dest_select_in) < NO) begin
                    m_stage[int'(dest_select_in)] = int'(src_select_in);
                end
            end
            for (int k = 0; k < NO; k++) begin
                if (update_in && (m_stage[k] != m_act[k]) && (BLANK > 0))
                    m_left[k] = BLANK;
                else if (m_left[k] > 0)
                    m_left[k] = m_left[k] - 1;
                if (update_in) m_act[k] = m_stage[k];
                m_blank[k] = (m_left[k] > 0);
                if (output_active_in[k] && (m_left[k] == 0) && (m_act[k] < NI)) begin
                    m_data[k*W +: W] = data_packed_in[m_act[k]*W +: W];
                    m_dv[k]          = dv_packed_in[m_act[k]];
                end else begin
                    m_data[k*W +: W] = '0;
                    m_dv[k]          = 1'b0;
                end
            end
        end
        model_ok = 1;
    end

    always @(negedge clk_in) begin
        if (model_ok) begin
            chk("cyc_data",  128'(data_packed_out), 128'(m_data));
            chk("cyc_dv",    128'(dv_packed_out),   128'(m_dv));
            chk("cyc_blank", 128'(blank_out),       128'(m_blank));
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations.
    // ------------------------------------------------------------------
    task automatic tick();
        @(negedge clk_in);
    endtask

    function automatic logic [W-1:0] out_ch(input int k);
        return data_packed_out[k*W +: W];
    endfunction

    function automatic logic [W*NO-1:0] all_out(input logic [W-1:0] v);
        return {NO{v}};
    endfunction

    task automatic set_in(input int i, input logic [W-1:0] v);
        data_packed_in[i*W +: W] = v;
    endtask

    initial begin
        rst_in           = 1'b1;
        wr_in            = 1'b0;
        update_in        = 1'b0;
        bcast_in         = 1'b0;
        src_select_in    = '0;
        dest_select_in   = '0;
        output_active_in = '0;
        dv_packed_in     = '1;
        set_in(0, 16'h1234);
        for (int i = 1; i < NI; i++) set_in(i, 16'hC0D0 + 16'(i));

        tick();
        tick();
        chk("rst_data",  128'(data_packed_out), 128'(0));
        chk("rst_dv",    128'(dv_packed_out),   128'(0));
        chk("rst_blank", 128'(blank_out),       128'(0));

        // After reset every active output routes input 0.
        rst_in           = 1'b0;
        output_active_in = '1;
        tick();
        chk("route0_data", 128'(data_packed_out), 128'(all_out(16'h1234)));
        chk("route0_dv",   128'(dv_packed_out),   128'(8'hFF));

        // Staged write alone changes nothing.
        wr_in = 1'b1; dest_select_in = 4'd3; src_select_in = 4'd5;
        tick();
        wr_in = 1'b0;
        chk("staged_no_effect", 128'(data_packed_out), 128'(all_out(16'h1234)));

        // Commit: output 3 blanks four cycles, then carries input 5.
        update_in = 1'b1;
        tick();
        update_in = 1'b0;
        chk("commit_blank",  128'(blank_out), 128'(8'h08));
        chk("commit_out3",   128'(out_ch(3)), 128'(16'h0000));
        chk("commit_dv3",    128'(dv_packed_out), 128'(8'hF7));
        chk("commit_out2",   128'(out_ch(2)), 128'(16'h1234));
        tick(); tick(); tick();
        chk("blank_4th", 128'(blank_out), 128'(8'h08));
        tick();
        chk("blank_done", 128'(blank_out), 128'(8'h00));
        chk("out3_src5",  128'(out_ch(3)), 128'(16'hC0D5));

        // Broadcast write and commit in the same cycle.
        wr_in = 1'b1; update_in = 1'b1; bcast_in = 1'b1; src_select_in = 4'd2;
        tick();
        wr_in = 1'b0; update_in = 1'b0; bcast_in = 1'b0;
        chk("bcast_blank", 128'(blank_out), 128'(8'hFF));
        chk("bcast_zero",  128'(data_packed_out), 128'(0));
        repeat (BLANK) tick();
        chk("bcast_done", 128'(blank_out), 128'(8'h00));
        chk("bcast_src2", 128'(data_packed_out), 128'(all_out(16'hC0D2)));

        // Identical commit again: no blanking.
        wr_in = 1'b1; update_in = 1'b1; bcast_in = 1'b1; src_select_in = 4'd2;
        tick();
        wr_in = 1'b0; update_in = 1'b0; bcast_in = 1'b0;
        chk("same_no_blank", 128'(blank_out), 128'(8'h00));
        chk("same_src2",     128'(data_packed_out), 128'(all_out(16'hC0D2)));

        // One-cycle latency from input data, dv passes through.
        set_in(2, 16'hBEEF);
        dv_packed_in[2] = 1'b0;
        tick();
        chk("lat_data", 128'(data_packed_out), 128'(all_out(16'hBEEF)));
        chk("lat_dv",   128'(dv_packed_out),   128'(8'h00));
        dv_packed_in[2] = 1'b1;

        // Write to a nonexistent output is ignored.
        wr_in = 1'b1; update_in = 1'b1; dest_select_in = 4'd8; src_select_in = 4'd1;
        tick();
        wr_in = 1'b0; update_in = 1'b0;
        chk("bad_dest_blank", 128'(blank_out), 128'(8'h00));
        chk("bad_dest_data",  128'(data_packed_out), 128'(all_out(16'hBEEF)));

        // Routing a nonexistent input gives zero data and dv.
        wr_in = 1'b1; update_in = 1'b1; dest_select_in = 4'd6; src_select_in = 4'd8;
        tick();
        wr_in = 1'b0; update_in = 1'b0;
        chk("bad_src_blank", 128'(blank_out), 128'(8'h40));
        repeat (BLANK) tick();
        chk("bad_src_out6", 128'(out_ch(6)), 128'(16'h0000));
        chk("bad_src_dv",   128'(dv_packed_out), 128'(8'hBF));

        // Disabling an output zeroes it on the next cycle.
        output_active_in[1] = 1'b0;
        tick();
        chk("inactive_out1", 128'(out_ch(1)), 128'(16'h0000));
        chk("inactive_dv",   128'(dv_packed_out), 128'(8'hBD));

        // A few cycles of changing data for the per-cycle compare.
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < NI; i++) set_in(i, 16'(16'h0101 * (n + 1) + i));
            dv_packed_in = 8'(8'h5A >> n);
            tick();
        end

        // Start blanking output 0, then reset with write/commit also high.
        wr_in = 1'b1; update_in = 1'b1; dest_select_in = 4'd0; src_select_in = 4'd7;
        tick();
        chk("preblank", 128'(blank_out), 128'(8'h01));
        rst_in = 1'b1; bcast_in = 1'b1; src_select_in = 4'd3;
        tick();
        rst_in = 1'b0; wr_in = 1'b0; update_in = 1'b0; bcast_in = 1'b0;
        chk("midrst_blank", 128'(blank_out), 128'(8'h00));
        chk("midrst_data",  128'(data_packed_out), 128'(0));
        chk("midrst_dv",    128'(dv_packed_out), 128'(0));

        set_in(0, 16'h1234);
        dv_packed_in = '1;
        tick();
        chk("postrst_out0", 128'(out_ch(0)), 128'(16'h1234));
        chk("postrst_out1", 128'(out_ch(1)), 128'(16'h0000));
        output_active_in = '1;
        tick();
        chk("postrst_all", 128'(data_packed_out), 128'(all_out(16'h1234)));
        chk("postrst_dv",  128'(dv_packed_out), 128'(8'hFF));

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
